btn_event_decoder: RTL and testbench

- Consumes the clean, debounced button level produced by the debounce checker, on the same 1 kHz tick clock.
- Classifies each press into events for the clock-setting control logic:
  - short-press pulse on release;
  - long-press pulse after a hold threshold;
  - optional auto-repeat pulses while the button stays held.
- One instance per button.

---
 rtl/btn_event_decoder.sv | 153 +++++++++++++++
 tb/tb_btn_event_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies presses of one debounced button into
// short, long and (optionally) auto-repeat events on the 1 kHz tick clock.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN enables auto-repeat pulses
// while the button stays held. When it is undefined, o_repeat is constant 0.
//
// Ports:
//   CLK      in   1 kHz tick clock
//   rst_n    in   asynchronous active-low reset
//   en       in   clock enable; 0 freezes state, counters and o_held
//   i_btn    in   debounced button level, 1 = pressed
//   o_short  out  one-cycle pulse, released before the long threshold
//   o_long   out  one-cycle pulse, long threshold reached while pressed
//   o_repeat out  one-cycle auto-repeat pulse while held
//   o_held   out  level, 1 while in HELD
module btn_event_decoder #(
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200,
  parameter int unsigned CNT_W     = 16
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic en,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int unsigned MAX_MS = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam bit          CFG_OK = (LONG_MS >= 2) && (LONG_MS <= 65535) &&
                                   (REPEAT_MS >= 1) && (REPEAT_MS <= 65535) &&
                                   ((64'(1) << CNT_W) > 64'(MAX_MS));

  // Elaboration-time guard on the parameter ranges.
  if (!CFG_OK) begin : g_bad_cfg
    $error("btn_event_decoder: illegal LONG_MS/REPEAT_MS/CNT_W combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic               held_q, held_d;
`ifdef BTN_AUTO_REPEAT_EN
  logic [CNT_W-1:0]   rpt_q, rpt_d;
  logic               repeat_q, repeat_d;
`endif

  // State, counter and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_q    <= '0;
      repeat_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      held_q   <= held_d;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_q    <= rpt_d;
      repeat_q <= repeat_d;
`endif
    end
  end

  // Next-state and output logic; pulses default low, everything else holds.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    held_d   = held_q;
`ifdef BTN_AUTO_REPEAT_EN
    rpt_d    = rpt_q;
    repeat_d = 1'b0;
`endif
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_btn) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          // Release wins over the long threshold on the same edge.
          if (!i_btn) begin
            state_d = ST_IDLE;
            short_d = 1'b1;
          end else if (cnt_q == CNT_W'(LONG_MS - 1)) begin
            state_d = ST_HELD;
            long_d  = 1'b1;
            held_d  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!i_btn) begin
            state_d = ST_IDLE;
            held_d  = 1'b0;
          end else begin
`ifdef BTN_AUTO_REPEAT_EN
            if (rpt_q == CNT_W'(REPEAT_MS - 1)) begin
              repeat_d = 1'b1;
              rpt_d    = '0;
            end else begin
              rpt_d = rpt_q + CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_d   = '0;
`endif
        end
      endcase
    end
  end

  assign o_short = short_q;
  assign o_long  = long_q;
  assign o_held  = held_q;
`ifdef BTN_AUTO_REPEAT_EN
  assign o_repeat = repeat_q;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomized plus directed bench for btn_event_decoder with LONG_MS=10,
// REPEAT_MS=4. A press-age reference model predicts every output each cycle.
module tb_btn_event_decoder;

  localparam int unsigned L = 10;
  localparam int unsigned R = 4;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst_n;
  logic en;
  logic i_btn;
  logic o_short, o_long, o_repeat, o_held;

  int checks = 0;
  int errors = 0;

  // Reference model: a press is active from its entry edge; age counts the
  // enabled edges since entry.
  bit m_active;
  bit m_held;
  int m_age;
  bit e_short, e_long, e_rep;

  btn_event_decoder #(.LONG_MS(L), .REPEAT_MS(R), .CNT_W(16)) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .en       (en),
    .i_btn    (i_btn),
    .o_short  (o_short),
    .o_long   (o_long),
    .o_repeat (o_repeat),
    .o_held   (o_held)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_held   = 1'b0;
    m_age    = 0;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_rep    = 1'b0;
  endtask

  task automatic model_edge(input logic b, input logic e);
    e_short = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (e) begin
      if (!m_active) begin
        if (b) begin
          m_active = 1'b1;
          m_age    = 0;
        end
      end else begin
        m_age++;
        if (!b) begin
          if (!m_held) e_short = 1'b1;
          m_active = 1'b0;
          m_held   = 1'b0;
        end else if (!m_held && m_age == int'(L)) begin
          e_long = 1'b1;
          m_held = 1'b1;
        end else if (m_held && REP_EN && ((m_age - int'(L)) % int'(R)) == 0) begin
          e_rep = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".short"},  o_short,  e_short);
    check({tag, ".long"},   o_long,   e_long);
    check({tag, ".repeat"}, o_repeat, e_rep);
    check({tag, ".held"},   o_held,   m_held);
  endtask

  task automatic step(input string tag, input logic b, input logic e);
    i_btn = b;
    en    = e;
    @(posedge CLK);
    model_edge(b, e);
    #1;
    compare_all(tag);
  endtask

  task automatic run(input string tag, input logic b, input int n);
    for (int i = 0; i < n; i++) step(tag, b, 1'b1);
  endtask

  // Asynchronous reset applied between edges, held for a few edges.
  task automatic pulse_reset(input string tag, input logic b, input int n);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    for (int i = 0; i < n; i++) step(tag, b, 1'b1);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    i_btn = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    for (int i = 0; i < 2; i++) step("reset_hold", 1'b0, 1'b1);
    #2;
    rst_n = 1'b1;

    // Short press of 5 cycles.
    run("short5", 1'b0, 2);
    run("short5", 1'b1, 5);
    run("short5", 1'b0, 3);

    // Long hold of 30 cycles.
    run("hold30", 1'b1, 30);
    run("hold30", 1'b0, 3);

    // Release sampled exactly on edge LONG_MS.
    run("edge10", 1'b1, 10);
    run("edge10", 1'b0, 3);

    // Enable gap of 7 cycles mid-PRESSED.
    run("engap", 1'b1, 4);
    for (int i = 0; i < 7; i++) step("engap_off", 1'b1, 1'b0);
    run("engap", 1'b1, 20);
    run("engap", 1'b0, 3);

    // Reset mid-HELD with the button kept pressed.
    run("rsthold", 1'b1, 15);
    pulse_reset("rsthold", 1'b1, 2);
    run("rsthold", 1'b1, 15);
    run("rsthold", 1'b0, 3);

    // Two 3-cycle presses separated by one idle cycle.
    run("double", 1'b1, 3);
    run("double", 1'b0, 1);
    run("double", 1'b1, 3);
    run("double", 1'b0, 3);

    // Randomized runs of button level, enable drops and occasional resets.
    begin
      logic lvl;
      lvl = 1'b0;
      for (int s = 0; s < 300; s++) begin
        int len;
        lvl = ~lvl;
        len = int'($urandom_range(1, 25));
        for (int i = 0; i < len; i++) begin
          step("rand", lvl, ($urandom % 8) != 0);
        end
        if (($urandom % 40) == 0) pulse_reset("rand_rst", lvl, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
